alu_nibble_seq: RTL and testbench

- Multi-cycle sequencer that sits directly upstream of the 4-bit combinational ALU (ports a/b/c/cin in; result/zero/overflow/carry out).
- Accepts a wide command (op, A, B) over a valid/ready handshake and drives the ALU one nibble per cycle, least significant nibble first, chaining carry between passes.
- Assembles the wide result and flags, then presents them on an output valid/ready handshake.
- Gives the datapath 4*NIBBLES-bit arithmetic and logic without widening the ALU.

---
 rtl/alu_nibble_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_nibble_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// Multi-cycle sequencer that drives a 4-bit ALU one nibble per cycle,
// LSB nibble first with chained carry, and presents the wide result.
module alu_nibble_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_c,
  output logic                 alu_cin,
  input  logic [3:0]           alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_zero,
  output logic                 out_overflow,
  output logic                 out_carry,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [2:0]      op_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    acc_r;
  logic [W-1:0]    acc_s;
  logic            cin_r;
  logic            top_ovf_r;
  logic            top_carry_r;
  logic            ready_r;
  logic            out_valid_r;
  logic [W-1:0]    out_result_r;
  logic            out_zero_r;
  logic            out_ovf_r;
  logic            out_carry_r;

  logic            accept_s;
  logic            last_s;
  logic            load_s;
  logic            drain_s;
  logic [3:0]      alu_a_s;
  logic [3:0]      alu_b_s;
  logic [2:0]      alu_c_s;
  logic            alu_cin_s;
  logic [W-1:0]    result_s;
  logic            ovf_s;
  logic            carry_s;
  logic            alu_zero_unused_s;

  // The ALU zero flag is not needed: out_zero is recomputed on the wide result.
  assign alu_zero_unused_s = alu_zero;

  assign accept_s = in_valid && ready_r && (state_r == ST_IDLE);
  assign last_s   = (idx_r == LAST_IDX);
  assign load_s   = (state_r == ST_DONE) && !out_valid_r;
  assign drain_s  = (state_r == ST_DONE) && out_valid_r && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_s = ST_DONE;
        else        state_s = ST_RUN;
      end
      ST_DONE: begin
        if (drain_s) state_s = ST_IDLE;
        else         state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // ALU drive: current nibble of the registered operands; compare ops run as subtract
  always_comb begin
    alu_a_s   = 4'h0;
    alu_b_s   = 4'h0;
    alu_c_s   = 3'b000;
    alu_cin_s = 1'b0;
    if (state_r == ST_RUN) begin
      alu_a_s = a_r[{idx_r, 2'b00} +: 4];
      alu_b_s = b_r[{idx_r, 2'b00} +: 4];
      case (op_r)
        OP_ADD: begin
          alu_c_s   = OP_ADD;
          alu_cin_s = (idx_r == {IW{1'b0}}) ? 1'b0 : cin_r;
        end
        OP_SUB, OP_LT, OP_EQ: begin
          alu_c_s   = OP_SUB;
          alu_cin_s = (idx_r == {IW{1'b0}}) ? 1'b1 : cin_r;
        end
        default: begin
          alu_c_s   = op_r;
          alu_cin_s = 1'b0;
        end
      endcase
    end else begin
      alu_c_s = 3'b000;
    end
  end

  assign alu_a   = alu_a_s;
  assign alu_b   = alu_b_s;
  assign alu_c   = alu_c_s;
  assign alu_cin = alu_cin_s;

  // Accumulator with the current pass's result merged into its nibble slot
  always_comb begin
    acc_s = acc_r;
    acc_s[{idx_r, 2'b00} +: 4] = alu_result;
  end

  // Command capture and per-pass accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b0;
      op_r        <= 3'b000;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      idx_r       <= {IW{1'b0}};
      acc_r       <= {W{1'b0}};
      cin_r       <= 1'b0;
      top_ovf_r   <= 1'b0;
      top_carry_r <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      if (accept_s) begin
        op_r  <= in_op;
        a_r   <= in_a;
        b_r   <= in_b;
        idx_r <= {IW{1'b0}};
        acc_r <= {W{1'b0}};
        cin_r <= 1'b0;
      end else if (state_r == ST_RUN) begin
        acc_r <= acc_s;
        cin_r <= alu_carry;
        if (last_s) begin
          top_ovf_r   <= alu_overflow;
          top_carry_r <= alu_carry;
          idx_r       <= {IW{1'b0}};
        end else begin
          idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Result assembly; compares reduce the subtract difference to a single bit
  always_comb begin
    result_s = acc_r;
    ovf_s    = top_ovf_r;
    carry_s  = top_carry_r;
    case (op_r)
      OP_ADD, OP_SUB: begin
        result_s = acc_r;
      end
      OP_LT: begin
        result_s = {{(W-1){1'b0}}, acc_r[W-1] ^ top_ovf_r};
      end
      OP_EQ: begin
        result_s = {{(W-1){1'b0}}, (acc_r == {W{1'b0}})};
      end
      default: begin
        ovf_s   = 1'b0;
        carry_s = 1'b0;
      end
    endcase
  end

  // Output registers: loaded once in DONE, held until the consumer takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {W{1'b0}};
      out_zero_r   <= 1'b0;
      out_ovf_r    <= 1'b0;
      out_carry_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= result_s;
      out_zero_r   <= (result_s == {W{1'b0}});
      out_ovf_r    <= ovf_s;
      out_carry_r  <= carry_s;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready     = ready_r;
  assign out_valid    = out_valid_r;
  assign out_result   = out_result_r;
  assign out_zero     = out_zero_r;
  assign out_overflow = out_ovf_r;
  assign out_carry    = out_carry_r;
  assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq: a 4-bit ALU model closes the loop and a
// scoreboard holds wide-arithmetic expectations until the result handshake.
module tb_alu_nibble_seq;
  localparam int N = 2;
  localparam int W = 4 * N;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [2:0]   alu_c;
  logic         alu_cin;
  logic [3:0]   alu_result;
  logic         alu_zero;
  logic         alu_overflow;
  logic         alu_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_overflow;
  logic         out_carry;
  logic         busy;
  logic [4:0]   alu_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t bp_e;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_carry(out_carry),
    .busy(busy)
  );

  // 4-bit combinational ALU the sequencer talks to
  always_comb begin
    alu_t        = 5'h00;
    alu_result   = 4'h0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_c)
      3'b000: begin
        alu_t        = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
        alu_result   = alu_t[3:0];
        alu_carry    = alu_t[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_t[3] != alu_a[3]);
      end
      3'b001: begin
        alu_t        = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'h0, alu_cin};
        alu_result   = alu_t[3:0];
        alu_carry    = alu_t[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_t[3] != alu_a[3]);
      end
      3'b010:  alu_result = ~alu_a;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      3'b110:  alu_result = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = {3'b000, (alu_a == alu_b)};
    endcase
    alu_zero = (alu_result == 4'h0);
  end

  // Wide reference computed directly at full operand width
  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (op)
      3'b000: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.o   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'b001, 3'b110, 3'b111: begin
        s   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        e.c = s[W];
        e.o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        if (op == 3'b001)      e.res = s[W-1:0];
        else if (op == 3'b110) e.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
        else                   e.res = {{(W-1){1'b0}}, (a == b)};
      end
      3'b010:  e.res = ~a;
      3'b011:  e.res = a & b;
      3'b100:  e.res = a | b;
      default: e.res = a ^ b;
    endcase
    e.z = (e.res == {W{1'b0}});
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command, wait (bounded) for acceptance, then scramble the inputs
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 3'($urandom);
    in_a  = W'($urandom);
    in_b  = W'($urandom);
    sb.push_back(ref_model(op, a, b));
  endtask

  // Wait for out_valid, compare against the scoreboard head, check drain
  task automatic collect(input string tag, input int exp_lat);
    int   cnt = 0;
    exp_t e;
    e = '0;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_result"}, 32'(out_result), 32'(e.res));
    check({tag, "_zero"}, 32'(out_zero), 32'(e.z));
    check({tag, "_overflow"}, 32'(out_overflow), 32'(e.o));
    check({tag, "_carry"}, 32'(out_carry), 32'(e.c));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_drained"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_alu_drive", 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Arithmetic, including the carry-chain observation on 0x0F+0x01
    send(3'b000, 8'h7F, 8'h01); collect("add_7f_01", N + 1);
    send(3'b000, 8'h0F, 8'h01);
    check("add_p0_alu_c", 32'(alu_c), 32'd0);
    check("add_p0_cin", 32'(alu_cin), 32'd0);
    check("add_p0_nibbles", 32'({alu_a, alu_b}), 32'h0000_00F1);
    @(posedge clk); #1;
    check("add_p1_cin", 32'(alu_cin), 32'd1);
    check("add_p1_nibbles", 32'({alu_a, alu_b}), 32'h0000_0000);
    collect("add_0f_01", N);
    send(3'b001, 8'h00, 8'h01);
    check("sub_p0_alu_c", 32'(alu_c), 32'd1);
    check("sub_p0_cin", 32'(alu_cin), 32'd1);
    collect("sub_00_01", N + 1);
    send(3'b001, 8'h05, 8'h05); collect("sub_05_05", N + 1);

    // Compares and logic ops
    send(3'b110, 8'h80, 8'h01); collect("lt_80_01", N + 1);
    send(3'b110, 8'h01, 8'h80); collect("lt_01_80", N + 1);
    send(3'b111, 8'h3C, 8'h3C); collect("eq_3c_3c", N + 1);
    send(3'b111, 8'h3C, 8'h3D); collect("eq_3c_3d", N + 1);
    send(3'b011, 8'hF0, 8'h3C); collect("and_f0_3c", N + 1);
    send(3'b010, 8'hA5, 8'h00); collect("not_a5", N + 1);
    send(3'b101, 8'hFF, 8'h0F); collect("xor_ff_0f", N + 1);
    for (int i = 0; i < 6; i++) begin
      send(3'($urandom_range(7)), W'($urandom), W'($urandom));
      collect("random_op", N + 1);
    end

    // Backpressure with a second command waiting on in_valid
    out_ready = 1'b0;
    bp_e = ref_model(3'b000, 8'h12, 8'h34);
    send(3'b000, 8'h12, 8'h34); collect("bp_first", N + 1);
    in_op = 3'b001; in_a = 8'h50; in_b = 8'h20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_result_held", 32'(out_result), 32'(bp_e.res));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_drain_ready", 32'(in_ready), 32'd1);
    check("bp_drain_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(ref_model(3'b001, 8'h50, 8'h20));
    @(negedge clk);
    check("bp_second_accepted", 32'({busy, in_ready}), 32'd2);
    collect("bp_second", N + 1);

    // Reset in the middle of a command
    send(3'b000, 8'h33, 8'h44);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alu_drive", 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);
    check("midrst_outputs", 32'({out_result, out_zero, out_overflow, out_carry}), 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send(3'b000, 8'h01, 8'h01); collect("post_rst_add", N + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
